// File: rtl/catcore_proto_pkg.sv
// CatCore 18-byte command protocol: frame geometry, opcodes, FSM encodings
// and the byte-slice helper shared by the initiator and its receiver.
package catcore_proto_pkg;

  localparam int FRAME_BYTES  = 18;
  localparam int FRAME_BITS   = FRAME_BYTES * 8;
  localparam int PAYLOAD_BITS = (FRAME_BYTES - 2) * 8;

  localparam logic [7:0] OP_SEND_TX     = 8'h40;  // "@"
  localparam logic [7:0] OP_SHOOT_FLAGS = 8'h41;  // "A"
  localparam logic [7:0] OP_AES_KEY     = 8'h42;  // "B"
  localparam logic [7:0] OP_AES_PT      = 8'h43;  // "C"
  localparam logic [7:0] OP_PRIV_EXEC   = 8'h44;  // "D"

  localparam logic [7:0] HYPER_SUB_A = 8'h41;
  localparam logic [7:0] HYPER_SUB_B = 8'h42;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_RESP
  } init_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  function automatic logic [7:0] byte_slice(input logic [FRAME_BITS-1:0] frame,
                                            input logic [4:0]            idx);
    return frame[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/catcore_cmd_initiator_if.sv
// Command/response bundle between the badge interconnect (master) and the
// CatCore command initiator (slave).
interface catcore_cmd_initiator_if;

  logic                                     cmd_valid;
  logic                                     cmd_ready;
  logic [7:0]                               cmd_opcode;
  logic [catcore_proto_pkg::PAYLOAD_BITS-1:0] cmd_payload;
  logic                                     expect_resp;
  logic                                     busy;
  logic                                     resp_valid;
  logic [catcore_proto_pkg::FRAME_BITS-1:0]   resp_data;
  logic                                     resp_timeout;

  modport master (
    output cmd_valid, cmd_opcode, cmd_payload, expect_resp,
    input  cmd_ready, busy, resp_valid, resp_data, resp_timeout
  );

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_payload, expect_resp,
    output cmd_ready, busy, resp_valid, resp_data, resp_timeout
  );

endinterface

// File: rtl/catcore_cmd_initiator_uart_rx_8n1.sv
// 8N1 UART receiver: two-flop synchronizer, qualified start detect, mid-bit
// sampling and stop-bit framing check; emits a byte with a one-cycle valid.
module uart_rx_8n1
  import catcore_proto_pkg::*;
#(
  parameter int BIT_CYCLES = 10752
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       valid_o
);

  localparam int            CW        = $clog2(BIT_CYCLES + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BIT_CYCLES / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);

  // sync_q[1] is the synchronized line, sync_q[2] its previous value.
  logic [2:0]    sync_q;
  rx_state_e     state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic [7:0]    byte_q;
  logic          valid_q;
  logic          rx_s;
  logic          rx_prev;

  assign rx_s    = sync_q[1];
  assign rx_prev = sync_q[2];
  assign byte_o  = byte_q;
  assign valid_o = valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= 3'b111;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[1:0], rx_i};
      valid_q <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          cnt_q <= '0;
          if (rx_prev && !rx_s) state_q <= RX_START;
        end
        RX_START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            // A line that is high again at mid-start was only a glitch.
            state_q <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q   <= '0;
            shift_q <= {rx_s, shift_q[7:1]};
            bit_q   <= bit_q + 1'b1;
            if (bit_q == 3'd7) state_q <= RX_STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q   <= '0;
            state_q <= RX_IDLE;
            if (rx_s) begin
              byte_q  <= shift_q;
              valid_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/catcore_cmd_initiator.sv
// Host-side CatCore initiator: frames opcode+payload+opcode, sends it 8N1
// (byte 17 first) and optionally collects an 18-byte response with timeout.
module catcore_cmd_initiator
  import catcore_proto_pkg::*;
#(
  parameter int BIT_CYCLES   = 10752,
  parameter int RESP_TIMEOUT = 10_334_000
) (
  input  logic                   clk,
  input  logic                   reset,
  catcore_cmd_initiator_if.slave cmd,
  output logic                   tx,
  input  logic                   rx
);

  localparam int             BCW      = $clog2(BIT_CYCLES + 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(BIT_CYCLES - 1);
  localparam int             TOW      = $clog2(RESP_TIMEOUT + 1);
  localparam logic [TOW-1:0] TO_LAST  = TOW'(RESP_TIMEOUT - 1);
  localparam logic [4:0]     LAST_IDX = 5'(FRAME_BYTES - 1);

  init_state_e           state_q;
  logic [FRAME_BITS-1:0] frame_q;
  logic                  expect_q;
  logic [4:0]            byte_idx_q;
  logic [2:0]            bit_idx_q;
  logic [7:0]            tx_byte_q;
  logic [BCW-1:0]        cyc_q;
  logic                  tx_q;
  logic [4:0]            resp_cnt_q;
  logic [TOW-1:0]        to_cnt_q;
  logic [FRAME_BITS-1:0] resp_shift_q;
  logic [FRAME_BITS-1:0] resp_data_q;
  logic                  resp_valid_q;
  logic                  resp_timeout_q;

  logic                  rx_valid;
  logic [7:0]            rx_byte;
  logic [FRAME_BITS-1:0] resp_shift_next;

  uart_rx_8n1 #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_rx (
    .clk    (clk),
    .reset  (reset),
    .rx_i   (rx),
    .byte_o (rx_byte),
    .valid_o(rx_valid)
  );

  // Newest byte lands at byte 17 so the first received byte ends at byte 0.
  assign resp_shift_next = {rx_byte, resp_shift_q[FRAME_BITS-1:8]};

  assign tx               = tx_q;
  assign cmd.cmd_ready    = (state_q == ST_IDLE);
  assign cmd.busy         = (state_q != ST_IDLE);
  assign cmd.resp_valid   = resp_valid_q;
  assign cmd.resp_data    = resp_data_q;
  assign cmd.resp_timeout = resp_timeout_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      frame_q        <= '0;
      expect_q       <= 1'b0;
      byte_idx_q     <= '0;
      bit_idx_q      <= '0;
      tx_byte_q      <= '0;
      cyc_q          <= '0;
      tx_q           <= 1'b1;
      resp_cnt_q     <= '0;
      to_cnt_q       <= '0;
      resp_shift_q   <= '0;
      resp_data_q    <= '0;
      resp_valid_q   <= 1'b0;
      resp_timeout_q <= 1'b0;
    end else begin
      resp_valid_q   <= 1'b0;
      resp_timeout_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          tx_q <= 1'b1;
          if (cmd.cmd_valid) begin
            frame_q    <= {cmd.cmd_opcode, cmd.cmd_payload, cmd.cmd_opcode};
            expect_q   <= cmd.expect_resp;
            byte_idx_q <= LAST_IDX;
            tx_byte_q  <= cmd.cmd_opcode;
            cyc_q      <= '0;
            tx_q       <= 1'b0;
            state_q    <= ST_START;
          end
        end
        ST_START: begin
          if (cyc_q == BIT_LAST) begin
            cyc_q     <= '0;
            bit_idx_q <= '0;
            tx_q      <= tx_byte_q[0];
            tx_byte_q <= {1'b0, tx_byte_q[7:1]};
            state_q   <= ST_DATA;
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end
        ST_DATA: begin
          if (cyc_q == BIT_LAST) begin
            cyc_q <= '0;
            if (bit_idx_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= ST_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
              tx_q      <= tx_byte_q[0];
              tx_byte_q <= {1'b0, tx_byte_q[7:1]};
            end
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end
        ST_STOP: begin
          if (cyc_q == BIT_LAST) begin
            cyc_q <= '0;
            if (byte_idx_q == 5'd0) begin
              resp_cnt_q <= '0;
              to_cnt_q   <= '0;
              state_q    <= expect_q ? ST_WAIT_RESP : ST_IDLE;
            end else begin
              byte_idx_q <= byte_idx_q - 5'd1;
              tx_byte_q  <= byte_slice(frame_q, byte_idx_q - 5'd1);
              tx_q       <= 1'b0;
              state_q    <= ST_START;
            end
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end
        ST_WAIT_RESP: begin
          // A good byte outranks a timeout landing on the same cycle.
          if (rx_valid) begin
            resp_shift_q <= resp_shift_next;
            to_cnt_q     <= '0;
            if (resp_cnt_q == LAST_IDX) begin
              resp_data_q  <= resp_shift_next;
              resp_valid_q <= 1'b1;
              state_q      <= ST_IDLE;
            end else begin
              resp_cnt_q <= resp_cnt_q + 1'b1;
            end
          end else if (to_cnt_q == TO_LAST) begin
            resp_timeout_q <= 1'b1;
            state_q        <= ST_IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_catcore_cmd_initiator.sv
// Directed bench for catcore_cmd_initiator with short bit time and timeout.
module tb_catcore_cmd_initiator;
  import catcore_proto_pkg::*;

  localparam int BC = 16;
  localparam int TO = 1000;

  logic clk = 1'b0;
  logic reset;
  logic rx;
  logic tx;

  int n_cmp = 0;
  int n_err = 0;
  int n_rv  = 0;
  int n_to  = 0;

  logic [7:0]   exp_wire [18];
  logic [143:0] grey_exp;
  logic [143:0] good_exp;
  logic [127:0] pl;
  string        grey = "grey{lmao_sandbox}";
  int           rv0, to0, m;

  catcore_cmd_initiator_if cmd_if ();

  catcore_cmd_initiator #(
    .BIT_CYCLES  (BC),
    .RESP_TIMEOUT(TO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .cmd  (cmd_if),
    .tx   (tx),
    .rx   (rx)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cmd_if.resp_valid === 1'b1) n_rv++;
    if (cmd_if.resp_timeout === 1'b1) n_to++;
  end

  task automatic chk(input string tag, input logic [143:0] got, input logic [143:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic send_cmd(input logic [7:0] op, input logic [127:0] payload, input logic er);
    @(negedge clk);
    cmd_if.cmd_valid   = 1'b1;
    cmd_if.cmd_opcode  = op;
    cmd_if.cmd_payload = payload;
    cmd_if.expect_resp = er;
    @(posedge clk);
    #1;
    cmd_if.cmd_valid = 1'b0;
    $display("cmd op=%02h payload=%032h expect_resp=%0d", op, payload, er);
  endtask

  // Walks the 2880 frame cycles after accept, checking every tx cycle and
  // collecting a mid-bit sample of each 10-bit symbol; pokes a busy-time request.
  task automatic chk_frame(input logic exp_resp);
    logic [9:0] sym [18];
    int bad_tx, bad_rdy, s, b, j;
    logic e;
    bad_tx  = 0;
    bad_rdy = 0;
    for (int n = 1; n <= 18 * 10 * BC; n++) begin
      @(negedge clk);
      if (n == 100) begin
        cmd_if.cmd_valid   = 1'b1;
        cmd_if.cmd_opcode  = 8'hFF;
        cmd_if.cmd_payload = '1;
        cmd_if.expect_resp = ~exp_resp;
      end
      if (n == 102) cmd_if.cmd_valid = 1'b0;
      s = (n - 1) / BC;
      b = s / 10;
      j = s % 10;
      if (j == 0) e = 1'b0;
      else if (j == 9) e = 1'b1;
      else e = exp_wire[b][j-1];
      if (tx !== e) bad_tx++;
      if ((n - 1) % BC == BC / 2) sym[b][j] = tx;
      if (cmd_if.cmd_ready !== 1'b0 || cmd_if.busy !== 1'b1) bad_rdy++;
    end
    for (int k = 0; k < 18; k++)
      chk($sformatf("tx_byte%0d", k), 144'(sym[k]), 144'({1'b1, exp_wire[k], 1'b0}));
    chk("tx_timing", 144'(bad_tx), 144'(0));
    chk("busy_span", 144'(bad_rdy), 144'(0));
    @(negedge clk);
    chk("ready_after_frame", 144'(cmd_if.cmd_ready), 144'(!exp_resp));
    $display("frame done bad_tx=%0d bad_rdy=%0d", bad_tx, bad_rdy);
  endtask

  task automatic uart_send(input logic [7:0] b, input logic stop);
    @(negedge clk);
    rx = 1'b0;
    repeat (BC) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BC) @(negedge clk);
    end
    rx = stop;
    repeat (BC) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic set_wire(input logic [7:0] op, input logic counting);
    exp_wire[0]  = op;
    exp_wire[17] = op;
    for (int w = 1; w <= 16; w++) exp_wire[w] = counting ? 8'(17 - w) : 8'h00;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    rx    = 1'b1;
    cmd_if.cmd_valid   = 1'b0;
    cmd_if.cmd_opcode  = '0;
    cmd_if.cmd_payload = '0;
    cmd_if.expect_resp = 1'b0;
    for (int i = 0; i < 18; i++) begin
      grey_exp[8*i +: 8] = grey[i];
      good_exp[8*i +: 8] = 8'hC0 + 8'(i);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx", 144'(tx), 144'(1));
    chk("rst_ready", 144'(cmd_if.cmd_ready), 144'(1));
    chk("rst_busy", 144'(cmd_if.busy), 144'(0));
    chk("rst_rv", 144'(cmd_if.resp_valid), 144'(0));
    chk("rst_to", 144'(cmd_if.resp_timeout), 144'(0));
    chk("rst_data", cmd_if.resp_data, 144'(0));
    reset = 1'b0;

    // 1: "@" with payload byte1 = "A", no response
    pl = '0;
    pl[7:0] = 8'h41;
    set_wire(8'h40, 1'b0);
    exp_wire[16] = 8'h41;
    send_cmd(OP_SEND_TX, pl, 1'b0);
    chk_frame(1'b0);
    chk("t1_no_rv", 144'(n_rv), 144'(0));

    // 2: "C" with an 18-byte reply
    set_wire(8'h43, 1'b0);
    send_cmd(OP_AES_PT, '0, 1'b1);
    chk_frame(1'b1);
    rv0 = n_rv;
    for (int i = 0; i < 18; i++) uart_send(grey[i], 1'b1);
    repeat (4) @(negedge clk);
    $display("reply grey received resp_valid_count=%0d", n_rv);
    chk("t2_rv_count", 144'(n_rv), 144'(rv0 + 1));
    chk("t2_data", cmd_if.resp_data, grey_exp);
    chk("t2_byte0", 144'(cmd_if.resp_data[7:0]), 144'(8'h67));
    chk("t2_byte17", 144'(cmd_if.resp_data[143:136]), 144'(8'h7D));
    chk("t2_ready", 144'(cmd_if.cmd_ready), 144'(1));
    chk("t2_no_to", 144'(n_to), 144'(0));

    // 3: no reply -> timeout 1000 cycles after WAIT_RESP entry (cycle 2881)
    set_wire(8'h42, 1'b0);
    send_cmd(OP_AES_KEY, '0, 1'b1);
    chk_frame(1'b1);
    rv0 = n_rv;
    to0 = n_to;
    m = 2881;
    while (m < 6000) begin
      @(negedge clk);
      m++;
      if (cmd_if.resp_timeout === 1'b1) break;
    end
    $display("timeout seen at cycle %0d", m);
    chk("t3_to_cycle", 144'(m), 144'(3881));
    chk("t3_ready", 144'(cmd_if.cmd_ready), 144'(1));
    repeat (2) @(negedge clk);
    chk("t3_to_pulse", 144'(n_to), 144'(to0 + 1));
    chk("t3_no_rv", 144'(n_rv), 144'(rv0));
    chk("t3_data_kept", cmd_if.resp_data, grey_exp);

    // 4: 10 reply bytes then silence -> timeout measured from the 10th byte
    pl = '0;
    pl[7:0] = HYPER_SUB_A;
    set_wire(8'h41, 1'b0);
    exp_wire[16] = 8'h41;
    send_cmd(OP_SHOOT_FLAGS, pl, 1'b1);
    chk_frame(1'b1);
    rv0 = n_rv;
    to0 = n_to;
    for (int i = 0; i < 10; i++) uart_send(8'h10 + 8'(i), 1'b1);
    m = 0;
    while (m < 3000) begin
      @(negedge clk);
      m++;
      if (cmd_if.resp_timeout === 1'b1) break;
    end
    $display("partial reply timeout after %0d cycles", m);
    chk("t4_to_delay", 144'(m), 144'(996));
    repeat (2) @(negedge clk);
    chk("t4_to_count", 144'(n_to), 144'(to0 + 1));
    chk("t4_no_rv", 144'(n_rv), 144'(rv0));
    chk("t4_data_kept", cmd_if.resp_data, grey_exp);

    // 5: glitch, a framing-error byte, then 18 good bytes
    for (int k = 0; k < 16; k++) pl[8*k +: 8] = 8'(k + 1);
    set_wire(8'h43, 1'b1);
    send_cmd(OP_AES_PT, pl, 1'b1);
    chk_frame(1'b1);
    rv0 = n_rv;
    to0 = n_to;
    @(negedge clk);
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    uart_send(8'h5A, 1'b0);
    repeat (20) @(negedge clk);
    for (int i = 0; i < 18; i++) uart_send(8'hC0 + 8'(i), 1'b1);
    repeat (4) @(negedge clk);
    $display("reply after glitch and bad byte resp_valid_count=%0d", n_rv);
    chk("t5_rv_count", 144'(n_rv), 144'(rv0 + 1));
    chk("t5_data", cmd_if.resp_data, good_exp);
    chk("t5_no_to", 144'(n_to), 144'(to0));

    // 6: reset during a data bit of wire byte 5, then a full new frame
    rv0 = n_rv;
    send_cmd(OP_PRIV_EXEC, '0, 1'b0);
    repeat (854) @(negedge clk);
    chk("t6_pre_tx", 144'(tx), 144'(0));
    reset = 1'b1;
    @(negedge clk);
    chk("t6_rst_tx", 144'(tx), 144'(1));
    chk("t6_rst_ready", 144'(cmd_if.cmd_ready), 144'(1));
    chk("t6_rst_data", cmd_if.resp_data, 144'(0));
    reset = 1'b0;
    $display("reset mid-frame applied");
    set_wire(8'h40, 1'b1);
    send_cmd(OP_SEND_TX, pl, 1'b0);
    chk_frame(1'b0);
    chk("t6_no_rv", 144'(n_rv), 144'(rv0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
